cordic_iter_sequencer: RTL

Control sequencer for a word-serial CORDIC engine: accepts one operand set per valid/ready handshake, loads the datapath registers, then steps the micro-rotation index through every iteration (driving the arctan ROM select and the barrel-shift amount), optionally runs one gain-compensation step, and presents the result with a held valid/ready handshake. It sits between the CoreCORDIC input/output ports and the shared single-stage rotation datapath, replacing the unrolled parallel pipeline where area matters.

---
 rtl/cordic_iter_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cordic_iter_sequencer.sv
// rtl/cordic_iter_sequencer.sv - word-serial CORDIC control sequencer (optional gain step: CORDIC_GAIN_COMP_EN)
module cordic_iter_sequencer #(
    parameter int ITERATIONS = 16,
    parameter int ITER_W     = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              LD_EN,
    output logic              ROT_EN,
    output logic [ITER_W-1:0] ITER_IDX,
    output logic              GAIN_EN,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              BUSY
);

    localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(ITERATIONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROTATE,
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN,
`endif
        S_DONE
    } state_t;

    state_t            state;
    logic [ITER_W-1:0] iter_idx_q;
    logic              ld_en_q;
    logic              rot_en_q;
    logic              gain_en_q;
    logic              dout_valid_q;
    logic              busy_q;

    // Output strobes are registered alongside the state so each one lines up
    // exactly with the state it belongs to.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            iter_idx_q   <= '0;
            ld_en_q      <= 1'b0;
            rot_en_q     <= 1'b0;
            gain_en_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ld_en_q      <= 1'b0;
            rot_en_q     <= 1'b0;
            gain_en_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            iter_idx_q   <= '0;
            case (state)
                S_IDLE: begin
                    if (DIN_VALID) begin
                        state   <= S_LOAD;
                        ld_en_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state    <= S_ROTATE;
                    rot_en_q <= 1'b1;
                end
                S_ROTATE: begin
                    if (iter_idx_q == LAST_IDX) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state     <= S_GAIN;
                        gain_en_q <= 1'b1;
`else
                        state        <= S_DONE;
                        dout_valid_q <= 1'b1;
`endif
                    end else begin
                        iter_idx_q <= iter_idx_q + ITER_W'(1);
                        rot_en_q   <= 1'b1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_GAIN: begin
                    state        <= S_DONE;
                    dout_valid_q <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (DOUT_READY) begin
                        // A waiting operand is taken on the same edge as the result.
                        if (DIN_VALID) begin
                            state   <= S_LOAD;
                            ld_en_q <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        dout_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign DIN_READY  = !RST && ((state == S_IDLE) || ((state == S_DONE) && DOUT_READY));
    assign LD_EN      = ld_en_q;
    assign ROT_EN     = rot_en_q;
    assign ITER_IDX   = iter_idx_q;
    assign GAIN_EN    = gain_en_q;
    assign DOUT_VALID = dout_valid_q;
    assign BUSY       = busy_q;

endmodule
